// File: rtl/s4ga_pkg.sv
// rtl/s4ga_pkg.sv - shared s4ga geometry helpers and config-streamer FSM states
package s4ga_pkg;

  localparam int S4GA_N    = 16;
  localparam int S4GA_K    = 4;
  localparam int S4GA_SI_W = 4;

  // Each field is padded up to a whole number of segments.
  function automatic int idx_segs(input int n, input int si_w);
    return ($clog2(n) + si_w - 1) / si_w;
  endfunction

  function automatic int mask_segs(input int k, input int si_w);
    return ((1 << k) + si_w - 1) / si_w;
  endfunction

  function automatic int segs_per_lut(input int n, input int k, input int si_w);
    return k * idx_segs(n, si_w) + mask_segs(k, si_w);
  endfunction

  function automatic int total_segs(input int n, input int k, input int si_w);
    return n * segs_per_lut(n, k, si_w);
  endfunction

  function automatic int addr_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  localparam int S4GA_SPL   = segs_per_lut(S4GA_N, S4GA_K, S4GA_SI_W);
  localparam int S4GA_TOTAL = total_segs(S4GA_N, S4GA_K, S4GA_SI_W);
  localparam int S4GA_AW    = addr_width(S4GA_TOTAL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_RUN
  } state_t;

endpackage

// File: rtl/s4ga_cfg_mem.sv
// rtl/s4ga_cfg_mem.sv - config segment register file, one sync write port, one async read port
module s4ga_cfg_mem #(
  parameter int DEPTH = 128,
  parameter int W     = 4,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  // Contents are deliberately not reset; a fresh load always rewrites every entry.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// rtl/s4ga_cfg_streamer.sv - loads one s4ga fabric config, then replays it to the core in consumption order
module s4ga_cfg_streamer
  import s4ga_pkg::*;
#(
  parameter int N    = 16,
  parameter int K    = 4,
  parameter int SI_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [SI_W-1:0] cfg_seg,
  input  logic            start,
  input  logic            stop,
  output logic [SI_W-1:0] si,
  output logic            core_rst,
  output logic            frame,
  output logic            loaded,
  output logic            busy
);

  localparam int TOTAL = total_segs(N, K, SI_W);
  localparam int AW    = addr_width(TOTAL);
  localparam logic [AW-1:0] LAST = AW'(TOTAL - 1);

  state_t          state_q;
  logic [AW-1:0]   wr_addr_q;
  logic [AW-1:0]   rd_addr_q;
  logic [AW-1:0]   rd_addr_d;
  logic [SI_W-1:0] rdata;
  logic            accept;
  logic            mem_we;

  logic            cfg_ready_q;
  logic [SI_W-1:0] si_q;
  logic            core_rst_q;
  logic            frame_q;
  logic            loaded_q;
  logic            busy_q;

  // The read port looks one address ahead so si_q can be registered straight from memory.
  always_comb begin
    rd_addr_d = '0;
    if (state_q == ST_RUN) begin
      rd_addr_d = (rd_addr_q == LAST) ? '0 : rd_addr_q + AW'(1);
    end
  end

  assign accept = (state_q == ST_LOAD) && cfg_valid && cfg_ready_q;
  assign mem_we = accept && !load_start && !rst;

  s4ga_cfg_mem #(
    .DEPTH (TOTAL),
    .W     (SI_W),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr_q),
    .wdata_i (cfg_seg),
    .raddr_i (rd_addr_d),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      cfg_ready_q <= 1'b0;
      si_q        <= '0;
      core_rst_q  <= 1'b1;
      frame_q     <= 1'b0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else if (load_start) begin
      state_q     <= ST_LOAD;
      wr_addr_q   <= '0;
      cfg_ready_q <= 1'b1;
      si_q        <= '0;
      core_rst_q  <= 1'b1;
      frame_q     <= 1'b0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (wr_addr_q == LAST) begin
              state_q     <= ST_IDLE;
              cfg_ready_q <= 1'b0;
              loaded_q    <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              wr_addr_q <= wr_addr_q + AW'(1);
            end
          end
        end
        ST_IDLE: begin
          if (start && loaded_q) begin
            state_q <= ST_SYNC;
            busy_q  <= 1'b1;
          end
        end
        ST_SYNC: begin
          state_q    <= ST_RUN;
          rd_addr_q  <= '0;
          si_q       <= rdata;
          frame_q    <= 1'b1;
          core_rst_q <= 1'b0;
        end
        ST_RUN: begin
          if (stop) begin
            state_q    <= ST_IDLE;
            si_q       <= '0;
            frame_q    <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_d;
            si_q      <= rdata;
            frame_q   <= (rd_addr_d == '0);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign si        = si_q;
  assign core_rst  = core_rst_q;
  assign frame     = frame_q;
  assign loaded    = loaded_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
// tb/tb_s4ga_cfg_streamer.sv - directed self-checking bench for s4ga_cfg_streamer
module tb_s4ga_cfg_streamer;

  localparam int N     = 16;
  localparam int K     = 4;
  localparam int SI_W  = 4;
  localparam int TOTAL = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_start;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [SI_W-1:0] cfg_seg;
  logic            start;
  logic            stop;
  logic [SI_W-1:0] si;
  logic            core_rst;
  logic            frame;
  logic            loaded;
  logic            busy;

  logic [SI_W-1:0] exp_mem [TOTAL];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  s4ga_cfg_streamer #(.N(N), .K(K), .SI_W(SI_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_seg    (cfg_seg),
    .start      (start),
    .stop       (stop),
    .si         (si),
    .core_rst   (core_rst),
    .frame      (frame),
    .loaded     (loaded),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses load_start, then accepts n segments of value (addr+base) mod 16.
  task automatic do_load(input int n, input int base, input bit toggle);
    int cnt = 0;
    int cyc = 0;
    logic rdy;
    logic [SI_W-1:0] seg;
    load_start = 1'b1;
    cfg_valid  = 1'b0;
    tick();
    load_start = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1 || loaded !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_enter cfg_ready=%b loaded=%b busy=%b required 1 0 1", cfg_ready, loaded, busy);
    end
    while (cnt < n && cyc < 1000) begin
      seg       = SI_W'((cnt + base) % 16);
      rdy       = cfg_ready;
      cfg_valid = toggle ? cyc[0] : 1'b1;
      cfg_seg   = seg;
      tick();
      if (cfg_valid && rdy) begin
        exp_mem[cnt] = seg;
        cnt++;
      end
      cyc++;
      if (cnt < TOTAL) begin
        checks++;
        if (loaded !== 1'b0 || cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL load_progress accepts=%0d loaded=%b cfg_ready=%b required 0 1", cnt, loaded, cfg_ready);
        end
      end
    end
    cfg_valid = 1'b0;
    checks++;
    if (cnt != n) begin
      errors++;
      $display("FAIL load_timeout accepts=%0d required %0d", cnt, n);
    end
  endtask

  task automatic check_loaded_idle(input string name);
    checks++;
    if (loaded !== 1'b1 || cfg_ready !== 1'b0 || busy !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL %s loaded=%b cfg_ready=%b busy=%b core_rst=%b required 1 0 0 1",
               name, loaded, cfg_ready, busy, core_rst);
    end
  endtask

  // Starts replay and checks the SYNC cycle plus ncyc RUN output cycles (t = 0..ncyc-1).
  task automatic run_replay(input int ncyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (core_rst !== 1'b1 || busy !== 1'b1 || si !== '0 || frame !== 1'b0) begin
      errors++;
      $display("FAIL sync_cycle core_rst=%b busy=%b si=%0d frame=%b required 1 1 0 0", core_rst, busy, si, frame);
    end
    for (int t = 0; t < ncyc; t++) begin
      tick();
      checks++;
      if (si !== exp_mem[t % TOTAL] || frame !== (t % TOTAL == 0) || core_rst !== 1'b0) begin
        errors++;
        $display("FAIL replay t=%0d si=%0d frame=%b core_rst=%b required %0d %b 0",
                 t, si, frame, core_rst, exp_mem[t % TOTAL], (t % TOTAL == 0));
      end
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || core_rst !== 1'b1 || si !== '0 || frame !== 1'b0 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL stop busy=%b core_rst=%b si=%0d frame=%b loaded=%b required 0 1 0 0 1",
               busy, core_rst, si, frame, loaded);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (core_rst !== 1'b1 || si !== '0 || loaded !== 1'b0 || busy !== 1'b0 ||
        cfg_ready !== 1'b0 || frame !== 1'b0) begin
      errors++;
      $display("FAIL reset core_rst=%b si=%0d loaded=%b busy=%b cfg_ready=%b frame=%b required 1 0 0 0 0 0",
               core_rst, si, loaded, busy, cfg_ready, frame);
    end
  endtask

  task automatic test_start_without_config();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || core_rst !== 1'b1 || si !== '0) begin
      errors++;
      $display("FAIL start_unloaded busy=%b core_rst=%b si=%0d required 0 1 0", busy, core_rst, si);
    end
  endtask

  task automatic test_full_load();
    do_load(TOTAL, 0, 1'b1);
    check_loaded_idle("full_load_done");
    cfg_valid = 1'b1;
    cfg_seg   = 4'hF;
    tick();
    tick();
    tick();
    cfg_valid = 1'b0;
    check_loaded_idle("valid_after_load");
  endtask

  task automatic test_replay();
    run_replay(140);
    do_stop();
    tick();
    checks++;
    if (busy !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL after_stop busy=%b core_rst=%b required 0 1", busy, core_rst);
    end
  endtask

  task automatic test_abort();
    do_load(50, 0, 1'b0);
    do_load(TOTAL, 5, 1'b0);
    check_loaded_idle("abort_reload_done");
    run_replay(20);
    do_stop();
  endtask

  task automatic test_collisions();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL start_in_load cfg_ready=%b busy=%b core_rst=%b required 1 1 1", cfg_ready, busy, core_rst);
    end
    do_load(TOTAL, 3, 1'b1);
    check_loaded_idle("load_after_start_in_load");

    start      = 1'b1;
    load_start = 1'b1;
    tick();
    start      = 1'b0;
    load_start = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1 || loaded !== 1'b0 || busy !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL start_and_load cfg_ready=%b loaded=%b busy=%b core_rst=%b required 1 0 1 1",
               cfg_ready, loaded, busy, core_rst);
    end
    do_load(TOTAL, 7, 1'b0);
    check_loaded_idle("load_after_collision");

    run_replay(10);
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || core_rst !== 1'b1 || si !== '0 || frame !== 1'b0) begin
      errors++;
      $display("FAIL stop_and_start busy=%b core_rst=%b si=%0d frame=%b required 0 1 0 0", busy, core_rst, si, frame);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_and_start_hold busy=%b required 0", busy);
    end

    run_replay(70);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (core_rst !== 1'b1 || loaded !== 1'b0 || busy !== 1'b0 || si !== '0 || frame !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_run core_rst=%b loaded=%b busy=%b si=%0d frame=%b required 1 0 0 0 0",
               core_rst, loaded, busy, si, frame);
    end
    test_start_without_config();
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    cfg_valid  = 1'b0;
    cfg_seg    = '0;
    start      = 1'b0;
    stop       = 1'b0;
    test_reset();
    test_start_without_config();
    test_full_load();
    test_replay();
    test_abort();
    test_collisions();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
